alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised-width ALU with an attached sequential multiply/divide unit (MDU).
//  The combinational ALU path serves single-cycle ops; the MDU runs MULT/MULTU/DIV/DIVU
//  one bit per cycle and writes the HI/LO registers. Sits in the execute stage of the
//  multicycle/pipelined MIPS core; the controller stalls on busy and reads HI/LO.
// PARAMETERS
//  WIDTH  32  datapath width in bits (>=4); MDU iteration count equals WIDTH
// PORTS
//  clk       in   1      clock, all state on rising edge
//  reset     in   1      asynchronous, active-high reset
//  a         in   WIDTH  operand A (ALU and MDU)
//  b         in   WIDTH  operand B (ALU and MDU)
//  alu_op    in   4      ALU operation select (table below)
//  y         out  WIDTH  ALU result (combinational)
//  zero      out  1      y == 0
//  overflow  out  1      signed overflow, ADD/SUB only, else 0
//  md_start  in   1      request MDU op; accepted only when busy==0
//  md_op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  hi_we     in   1      MTHI: hi <= a
//  lo_we     in   1      MTLO: lo <= a
//  busy      out  1      MDU operating; new starts and HI/LO writes dropped
//  done      out  1      one-cycle pulse: HI/LO just updated by MDU
//  hi, lo    out  WIDTH  HI/LO registers
// BEHAVIOUR
//  ALU (pure combinational, independent of MDU state):
//   0000 AND, 0001 OR, 0011 XOR, 0100 NOR, 0010 ADD, 0110 SUB (a+~b+1),
//   0111 SLT signed -> {0..,lt}, 0101 SLTU unsigned -> {0..,lt}, others y=0.
//   overflow: ADD: a,b same sign and sum sign differs; SUB: a,b differ in sign and
//   result sign differs from a. Wraps modulo 2^WIDTH. zero tracks y for every op.
//  Reset (async): state=IDLE, busy=0, done=0, hi=0, lo=0, internal regs=0.
//  FSM IDLE -> CALC -> ADJ -> IDLE:
//   IDLE: md_start=1 latches a,b,md_op (operands taken as magnitudes for signed ops,
//    sign flags stored); next state CALC, counter=WIDTH-1. busy=1 from next cycle.
//   CALC: one shift-add (mul) / restoring shift-subtract (div) step per cycle;
//    after WIDTH cycles (counter==0) -> ADJ.
//   ADJ: apply sign fix-up, write {hi,lo}; -> IDLE. done=1 and busy=0 in the cycle
//    after the ADJ edge. busy is high for exactly WIDTH+1 cycles per op.
//  Results: MULT/MULTU: {hi,lo} = full 2*WIDTH product (signed/unsigned).
//   DIV/DIVU: lo=quotient (truncate toward zero), hi=remainder (sign of dividend).
//   Divide by zero (both): lo={WIDTH{1}}, hi=a; no trap.
//   DIV MIN/-1: lo=MIN, hi=0.
//  HI/LO writes: hi_we/lo_we in IDLE write a at the edge; both may fire together.
//   md_start together with hi_we/lo_we in IDLE: start wins, writes dropped.
//   hi_we/lo_we or md_start while busy: ignored, no side effect.
//  Reset mid-op: abort immediately, HI/LO cleared, no done pulse.
//  Operands a/b may change after acceptance without affecting the running op.
// TESTING
//  (WIDTH=32 unless stated)
//  1 ALU: SUB a=80000000 b=00000001 -> y=7FFFFFFF overflow=1 zero=0;
//    ADD a=FFFFFFFF b=1 -> y=0 zero=1 overflow=0.
//  2 SLT vs SLTU a=00000001 b=FFFFFFFF -> SLT y=0, SLTU y=1; NOR a=b=0 -> y=FFFFFFFF.
//  3 MULT a=FFFFFFFD(-3) b=7 -> busy 33 cycles, done pulse once, hi=FFFFFFFF
//    lo=FFFFFFEB; MULTU same operands -> hi=00000006 lo=FFFFFFEB.
//  4 DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIVU a=7 b=0 -> lo=FFFFFFFF
//    hi=00000007; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  5 md_start and hi_we pulsed while busy -> ignored; hi/lo reflect only first op,
//    one done pulse; MTHI a=1234 in IDLE -> hi=00001234 next cycle.
//  6 Assert reset at CALC cycle 10 -> busy=0, done=0, hi=lo=0 immediately;
//    WIDTH=8 MULTU a=FF b=FF -> hi=FE lo=01 after 9 busy cycles.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Execute-stage bundle between the MIPS controller/datapath and the ALU + multiply/divide unit.
// The controller side is the master; alu_mdu is the slave.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             overflow;
    logic             md_start;
    logic [1:0]       md_op;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, alu_op, md_start, md_op, hi_we, lo_we,
        input  y, zero, overflow, busy, done, hi, lo
    );

    modport slave (
        input  a, b, alu_op, md_start, md_op, hi_we, lo_we,
        output y, zero, overflow, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Combinational ALU plus a bit-serial multiply/divide unit that owns the HI/LO registers.
// Signed MDU ops run on magnitudes; the sign fix-up happens in a single ADJ cycle.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int DW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADJ  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
        return ~v + DW'(1);
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        sum_c;
    logic [WIDTH-1:0]        dif_c;
    logic [WIDTH-1:0]        y_c;
    logic                    ovf_c;

    assign a_s   = bus.a;
    assign b_s   = bus.b;
    assign sum_c = bus.a + bus.b;
    assign dif_c = bus.a + ~bus.b + WIDTH'(1);

    always_comb begin
        y_c   = '0;
        ovf_c = 1'b0;
        case (bus.alu_op)
            4'b0000: y_c = bus.a & bus.b;
            4'b0001: y_c = bus.a | bus.b;
            4'b0011: y_c = bus.a ^ bus.b;
            4'b0100: y_c = ~(bus.a | bus.b);
            4'b0010: begin
                y_c   = sum_c;
                ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0110: begin
                y_c   = dif_c;
                ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0111: y_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'b0101: y_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: y_c = '0;
        endcase
    end

    assign bus.y        = y_c;
    assign bus.zero     = (y_c == '0);
    assign bus.overflow = ovf_c;

    // MDU state: acc holds the product high half / partial remainder, qr the multiplier / quotient.
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [DW-1:0]      prod_mag;

    assign mul_sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_q, qr_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign prod_mag  = {acc_q, qr_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.md_start) begin
                    op_d    = bus.md_op;
                    neg_a_d = ~bus.md_op[0] & bus.a[WIDTH-1];
                    neg_b_d = ~bus.md_op[0] & bus.b[WIDTH-1];
                    qr_d    = neg_a_d ? neg_w(bus.a) : bus.a;
                    mcand_d = neg_b_d ? neg_w(bus.b) : bus.b;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = S_CALC;
                end else begin
                    if (bus.hi_we) hi_d = bus.a;
                    if (bus.lo_we) lo_d = bus.a;
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    // Restoring divide: keep the subtraction only when it did not go negative.
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    qr_d  = {mul_sum[0], qr_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = S_ADJ;
            end
            S_ADJ: begin
                if (op_q[1]) begin
                    lo_d = (neg_a_q ^ neg_b_q) ? neg_w(qr_q) : qr_q;
                    hi_d = neg_a_q ? neg_w(acc_q) : acc_q;
                    if (mcand_q == '0) lo_d = '1;
                end else begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? neg_dw(prod_mag) : prod_mag;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed and random ALU/MDU checks against a plain-arithmetic reference,
// plus a WIDTH=8 instance for the small-width multiply case.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus ();
    alu_mdu_if #(.WIDTH(8))  bus8 ();

    alu_mdu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_mdu #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

    function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] y, output logic ov);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        y  = '0;
        ov = 1'b0;
        case (op)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd3: y = a ^ b;
            4'd4: y = ~(a | b);
            4'd2: begin s = sa + sb; y = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
            4'd6: begin s = sa - sb; y = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
            4'd7: y = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: y = (a < b) ? 32'd1 : 32'd0;
            default: y = '0;
        endcase
    endfunction

    function automatic void mdu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        logic [63:0] p;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin t = sa * sb; p = t; {hi, lo} = p; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
            2'd2: begin
                if (b == 32'd0) begin lo = '1; hi = a; end
                else begin t = sa / sb; lo = t[31:0]; t = sa % sb; hi = t[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    function automatic void mdu_model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                       output logic [7:0] hi, output logic [7:0] lo);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int ua = int'(a);
        int ub = int'(b);
        int t;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin t = sa * sb; {hi, lo} = t[15:0]; end
            2'd1: begin t = ua * ub; {hi, lo} = t[15:0]; end
            2'd2: begin
                if (b == 8'd0) begin lo = '1; hi = a; end
                else begin t = sa / sb; lo = t[7:0]; t = sa % sb; hi = t[7:0]; end
            end
            default: begin
                if (b == 8'd0) begin lo = '1; hi = a; end
                else begin t = ua / ub; lo = t[7:0]; t = ua % ub; hi = t[7:0]; end
            end
        endcase
    endfunction

    task automatic run_md32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int bc, output int dc);
        @(negedge clk);
        bus.md_op = op; bus.a = a; bus.b = b; bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        bc = 0; dc = 0;
        for (int g = 0; g < 200 && bus.busy; g++) begin
            bc++;
            if (bus.done) dc++;
            @(negedge clk);
        end
        if (bus.done) dc++;
        @(negedge clk);
        if (bus.done) dc++;
    endtask

    task automatic run_md8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           output int bc, output int dc);
        @(negedge clk);
        bus8.md_op = op; bus8.a = a; bus8.b = b; bus8.md_start = 1'b1;
        @(negedge clk);
        bus8.md_start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bc = 0; dc = 0;
        for (int g = 0; g < 100 && bus8.busy; g++) begin
            bc++;
            if (bus8.done) dc++;
            @(negedge clk);
        end
        if (bus8.done) dc++;
        @(negedge clk);
        if (bus8.done) dc++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu_directed;
        logic [3:0]  ops [5] = '{4'b0110, 4'b0010, 4'b0111, 4'b0101, 4'b0100};
        logic [31:0] as  [5] = '{32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0};
        logic [31:0] bs  [5] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] ys  [5] = '{32'h7FFFFFFF, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF};
        logic        zs  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        os  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.alu_op = ops[i]; bus.a = as[i]; bus.b = bs[i];
            #1;
            n_checks++; if (bus.y !== ys[i]) begin n_fail++; $display("FAIL alu_dir_y[%0d]: got %h want %h", i, bus.y, ys[i]); end
            n_checks++; if (bus.zero !== zs[i]) begin n_fail++; $display("FAIL alu_dir_zero[%0d]: got %b want %b", i, bus.zero, zs[i]); end
            n_checks++; if (bus.overflow !== os[i]) begin n_fail++; $display("FAIL alu_dir_ovf[%0d]: got %b want %b", i, bus.overflow, os[i]); end
        end
    endtask

    task automatic test_alu_random;
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] ey;
        logic        eo;
        for (int i = 0; i < 300; i++) begin
            bus.alu_op = 4'($urandom_range(0, 15));
            bus.a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            bus.b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            #1;
            alu_model(bus.alu_op, bus.a, bus.b, ey, eo);
            n_checks++; if (bus.y !== ey) begin n_fail++; $display("FAIL alu_rnd_y op=%h a=%h b=%h: got %h want %h", bus.alu_op, bus.a, bus.b, bus.y, ey); end
            n_checks++; if (bus.zero !== (ey == 32'd0)) begin n_fail++; $display("FAIL alu_rnd_zero op=%h: got %b want %b", bus.alu_op, bus.zero, (ey == 32'd0)); end
            n_checks++; if (bus.overflow !== eo) begin n_fail++; $display("FAIL alu_rnd_ovf op=%h a=%h b=%h: got %b want %b", bus.alu_op, bus.a, bus.b, bus.overflow, eo); end
        end
        bus.alu_op = 4'd0;
    endtask

    task automatic test_mdu_directed;
        logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] as  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h7, 32'h80000000};
        logic [31:0] bs  [5] = '{32'h7, 32'h7, 32'h2, 32'h0, 32'hFFFFFFFF};
        logic [31:0] his [5] = '{32'hFFFFFFFF, 32'h6, 32'hFFFFFFFF, 32'h7, 32'h0};
        logic [31:0] los [5] = '{32'hFFFFFFEB, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        int bc, dc;
        for (int i = 0; i < 5; i++) begin
            run_md32(ops[i], as[i], bs[i], bc, dc);
            n_checks++; if (bc != 33) begin n_fail++; $display("FAIL md_dir_busy[%0d]: got %0d cycles want 33", i, bc); end
            n_checks++; if (dc != 1) begin n_fail++; $display("FAIL md_dir_done[%0d]: got %0d pulses want 1", i, dc); end
            n_checks++; if (bus.hi !== his[i]) begin n_fail++; $display("FAIL md_dir_hi[%0d]: got %h want %h", i, bus.hi, his[i]); end
            n_checks++; if (bus.lo !== los[i]) begin n_fail++; $display("FAIL md_dir_lo[%0d]: got %h want %h", i, bus.lo, los[i]); end
        end
    endtask

    task automatic test_mdu_random;
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
        int bc, dc;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i % 9 == 0) a = 32'h80000000;
            mdu_model(op, a, b, eh, el);
            run_md32(op, a, b, bc, dc);
            n_checks++; if (bc != 33 || dc != 1) begin n_fail++; $display("FAIL md_rnd_timing op=%0d: got busy=%0d done=%0d want 33/1", op, bc, dc); end
            n_checks++; if (bus.hi !== eh) begin n_fail++; $display("FAIL md_rnd_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.hi, eh); end
            n_checks++; if (bus.lo !== el) begin n_fail++; $display("FAIL md_rnd_lo op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.lo, el); end
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] hi_before;
        int dc = 0;
        @(negedge clk);
        bus.md_op = 2'd0; bus.a = 32'hFFFFFFFD; bus.b = 32'd7; bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        repeat (4) @(negedge clk);
        hi_before = bus.hi;
        bus.md_start = 1'b1; bus.md_op = 2'd2; bus.a = 32'd100; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n_checks++; if (bus.hi !== hi_before) begin n_fail++; $display("FAIL busy_hi_we: got %h want %h", bus.hi, hi_before); end
        for (int g = 0; g < 80; g++) begin
            if (bus.done) dc++;
            @(negedge clk);
        end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", dc); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_settled: got %b want 0", bus.busy); end
        n_checks++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL busy_hi: got %h want ffffffff", bus.hi); end
        n_checks++; if (bus.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL busy_lo: got %h want ffffffeb", bus.lo); end
    endtask

    task automatic test_hilo_writes;
        int bc, dc;
        bus.a = 32'h1234; bus.hi_we = 1'b1;
        @(negedge clk);
        bus.hi_we = 1'b0;
        n_checks++; if (bus.hi !== 32'h00001234) begin n_fail++; $display("FAIL mthi_hi: got %h want 00001234", bus.hi); end
        n_checks++; if (bus.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want ffffffeb", bus.lo); end
        bus.a = 32'hCAFE0001; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n_checks++; if (bus.hi !== 32'hCAFE0001) begin n_fail++; $display("FAIL mt_both_hi: got %h want cafe0001", bus.hi); end
        n_checks++; if (bus.lo !== 32'hCAFE0001) begin n_fail++; $display("FAIL mt_both_lo: got %h want cafe0001", bus.lo); end
        bus.a = 32'd100; bus.b = 32'd7; bus.md_op = 2'd3; bus.md_start = 1'b1;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n_checks++; if (bus.hi !== 32'hCAFE0001) begin n_fail++; $display("FAIL start_wins_hi: got %h want cafe0001", bus.hi); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_wins_busy: got %b want 1", bus.busy); end
        bc = 0; dc = 0;
        for (int g = 0; g < 200 && bus.busy; g++) begin bc++; @(negedge clk); end
        if (bus.done) dc++;
        n_checks++; if (bc != 33 || dc != 1) begin n_fail++; $display("FAIL start_wins_timing: got busy=%0d done=%0d want 33/1", bc, dc); end
        n_checks++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin n_fail++; $display("FAIL start_wins_result: got hi=%h lo=%h want 2/e", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid_op;
        int dc = 0;
        int bs = 0;
        @(negedge clk);
        bus.md_op = 2'd1; bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.md_start = 1'b1;
        @(negedge clk);
        bus.md_start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", bus.done); end
        n_checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
        @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (bus.done) dc++;
            if (bus.busy) bs++;
        end
        n_checks++; if (dc != 0 || bs != 0) begin n_fail++; $display("FAIL rst_mid_after: got done=%0d busy=%0d want 0/0", dc, bs); end
    endtask

    task automatic test_width8;
        logic [1:0] op;
        logic [7:0] a, b, eh, el;
        int bc, dc;
        run_md8(2'd1, 8'hFF, 8'hFF, bc, dc);
        n_checks++; if (bc != 9 || dc != 1) begin n_fail++; $display("FAIL w8_timing: got busy=%0d done=%0d want 9/1", bc, dc); end
        n_checks++; if (bus8.hi !== 8'hFE || bus8.lo !== 8'h01) begin n_fail++; $display("FAIL w8_multu: got hi=%h lo=%h want fe/01", bus8.hi, bus8.lo); end
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            if (i % 7 == 0) begin a = 8'h80; b = 8'hFF; end
            mdu_model8(op, a, b, eh, el);
            run_md8(op, a, b, bc, dc);
            n_checks++; if (bus8.hi !== eh || bus8.lo !== el || bc != 9) begin
                n_fail++;
                $display("FAIL w8_rnd op=%0d a=%h b=%h: got hi=%h lo=%h busy=%0d want %h/%h/9", op, a, b, bus8.hi, bus8.lo, bc, eh, el);
            end
        end
    endtask

    initial begin
        bus.a = '0; bus.b = '0; bus.alu_op = '0; bus.md_start = 1'b0; bus.md_op = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.alu_op = '0; bus8.md_start = 1'b0; bus8.md_op = '0;
        bus8.hi_we = 1'b0; bus8.lo_we = 1'b0;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_mdu_directed();
        test_mdu_random();
        test_busy_ignore();
        test_hilo_writes();
        test_reset_mid_op();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
